// File: rtl/dmem_resp.sv
// Word-addressed data memory with a fixed-latency valid/ready request/response handshake.
// Define DMEM_RESP_ERR_EN to flag out-of-range addresses; otherwise the word index wraps modulo NMEM and rsp_err stays 0.
module dmem_resp #(
    parameter int NMEM = 128,
    parameter int WAIT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         AW       = $clog2(NMEM);
    localparam logic [3:0] CNT_INIT = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t          state, state_nxt;
    logic [3:0]      cnt, cnt_nxt;
    logic            enter_resp;

    logic            cap_wr;
    logic [AW-1:0]   cap_idx;
    logic [31:0]     cap_wdata;
    logic [3:0]      cap_be;
    logic            cap_err;

    logic            acc_wr;
    logic [AW-1:0]   acc_idx;
    logic [31:0]     acc_wdata;
    logic [3:0]      acc_be;
    logic            acc_err;

    logic            req_err;
    logic            unused_addr;
    logic [31:0]     mem [NMEM];
    logic [31:0]     rd_word;
    logic [31:0]     wr_word;
    logic [31:0]     rd_result;
    logic [31:0]     rsp_rdata_q;
    logic            rsp_err_q;

`ifdef DMEM_RESP_ERR_EN
    assign req_err     = |req_addr[31:AW+2];
    assign unused_addr = ^req_addr[1:0];
`else
    assign req_err     = 1'b0;
    assign unused_addr = ^{req_addr[31:AW+2], req_addr[1:0]};
`endif

    // NOTE: every signal gets a default at the top of an always_comb, so no path can leave it unassigned and infer a latch.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        enter_resp = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (WAIT == 0) begin
                        state_nxt  = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt  = ST_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // With WAIT=0 the access happens on the accept edge, so it must use the live request inputs.
    always_comb begin
        if (state == ST_IDLE) begin
            acc_wr    = req_wr;
            acc_idx   = req_addr[AW+1:2];
            acc_wdata = req_wdata;
            acc_be    = req_be;
            acc_err   = req_err;
        end else begin
            acc_wr    = cap_wr;
            acc_idx   = cap_idx;
            acc_wdata = cap_wdata;
            acc_be    = cap_be;
            acc_err   = cap_err;
        end
    end

    always_comb begin
        rd_word = mem[acc_idx];
        wr_word = rd_word;
        for (int i = 0; i < 4; i++) begin
            if (acc_be[i]) begin
                wr_word[8*i +: 8] = acc_wdata[8*i +: 8];
            end
        end
        if (acc_err) begin
            rd_result = '0;
        end else if (acc_wr) begin
            rd_result = wr_word;
        end else begin
            rd_result = rd_word;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= 4'd0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (enter_resp) begin
                rsp_rdata_q <= rd_result;
                rsp_err_q   <= acc_err;
            end
        end
    end

    // Request capture is pure data, qualified by the accept condition.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && req_valid) begin
            cap_wr    <= req_wr;
            cap_idx   <= req_addr[AW+1:2];
            cap_wdata <= req_wdata;
            cap_be    <= req_be;
            cap_err   <= req_err;
        end
    end

    // NOTE: the array has no reset: contents must survive rst, and a reset term would prevent RAM mapping.
    always_ff @(posedge clk) begin
        if (enter_resp && !rst && acc_wr && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: one WAIT=2 and one WAIT=0 instance, directed vector table,
// reset corner sequences, back-to-back scoreboard and randomized traffic against a memory model.
module tb_dmem_resp;

    localparam int NMEM = 128;
    localparam int AW   = 7;
`ifdef DMEM_RESP_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk;
    logic [1:0]  rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_wr;
    logic [1:0]  rsp_ready;
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_be    [2];
    wire  [1:0]  req_ready;
    wire  [1:0]  rsp_valid;
    wire  [1:0]  rsp_err;
    wire  [31:0] rsp_rdata [2];

    int n_checks;
    int n_errors;

    logic [31:0] mem_m [2][NMEM];

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          hold;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs [11];

    dmem_resp #(.NMEM(NMEM), .WAIT(2)) u_dut_w2 (
        .clk       (clk),
        .rst       (rst[0]),
        .req_valid (req_valid[0]),
        .req_ready (req_ready[0]),
        .req_wr    (req_wr[0]),
        .req_addr  (req_addr[0]),
        .req_wdata (req_wdata[0]),
        .req_be    (req_be[0]),
        .rsp_valid (rsp_valid[0]),
        .rsp_ready (rsp_ready[0]),
        .rsp_rdata (rsp_rdata[0]),
        .rsp_err   (rsp_err[0])
    );

    dmem_resp #(.NMEM(NMEM), .WAIT(0)) u_dut_w0 (
        .clk       (clk),
        .rst       (rst[1]),
        .req_valid (req_valid[1]),
        .req_ready (req_ready[1]),
        .req_wr    (req_wr[1]),
        .req_addr  (req_addr[1]),
        .req_wdata (req_wdata[1]),
        .req_be    (req_be[1]),
        .rsp_valid (rsp_valid[1]),
        .rsp_ready (rsp_ready[1]),
        .rsp_rdata (rsp_rdata[1]),
        .rsp_err   (rsp_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wait_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: a plain word array, indexed by byte address / 4 modulo the depth.
    function automatic void model(input int d, input logic wr, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [3:0] be,
                                  output logic [31:0] exp_rd, output logic exp_err);
        int          idx;
        logic [31:0] w;
        idx     = int'((addr / 4) % NMEM);
        exp_err = ERR_EN && ((addr / (4 * NMEM)) != 0);
        exp_rd  = '0;
        if (!exp_err) begin
            w = mem_m[d][idx];
            if (wr) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) w[8*i +: 8] = wdata[8*i +: 8];
                end
                mem_m[d][idx] = w;
            end
            exp_rd = w;
        end
    endfunction

    task automatic do_txn(input int d, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int hold,
                          output logic [31:0] rd, output logic er);
        int    n;
        int    lat;
        string tag;
        tag = $sformatf("i%0d a%08h", d, addr);
        rd  = '0;
        er  = 1'b0;
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_wr[d]    = wr;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_be[d]    = be;
        n = 0;
        while (!req_ready[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[d]) begin
            check({tag, " accept_timeout"}, 32'd1, 32'd0);
            req_valid[d] = 1'b0;
            return;
        end
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        req_valid[d] = 1'b0;
        req_wr[d]    = 1'($urandom);
        req_addr[d]  = $urandom;
        req_wdata[d] = $urandom;
        n = 0;
        while (!rsp_valid[d] && n < 50) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            n++;
        end
        if (!rsp_valid[d]) begin
            check({tag, " rsp_timeout"}, 32'd1, 32'd0);
            return;
        end
        check({tag, " latency"}, 32'(lat), 32'(wait_of(d) + 1));
        rd = rsp_rdata[d];
        er = rsp_err[d];
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, " hold_valid"}, 32'(rsp_valid[d]), 32'd1);
            check({tag, " hold_ready"}, 32'(req_ready[d]), 32'd0);
            check({tag, " hold_data"}, rsp_rdata[d], rd);
            check({tag, " hold_err"}, 32'(rsp_err[d]), 32'(er));
        end
        rsp_ready[d] = 1'b1;
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        check({tag, " idle_ready"}, 32'(req_ready[d]), 32'd1);
        check({tag, " idle_valid"}, 32'(rsp_valid[d]), 32'd0);
    endtask

    task automatic rst_mid(input int d, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int after, input logic exp_resp);
        int    n;
        string tag;
        tag = $sformatf("rst i%0d after%0d", d, after);
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_wr[d]    = wr;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_be[d]    = 4'hF;
        n = 0;
        while (!req_ready[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid[d] = 1'b0;
        for (int k = 1; k < after; k++) @(negedge clk);
        check({tag, " pre_valid"}, 32'(rsp_valid[d]), 32'(exp_resp));
        rst[d] = 1'b1;
        #1;
        check({tag, " valid"}, 32'(rsp_valid[d]), 32'd0);
        check({tag, " ready"}, 32'(req_ready[d]), 32'd1);
        check({tag, " rdata"}, rsp_rdata[d], 32'd0);
        check({tag, " err"}, 32'(rsp_err[d]), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check({tag, " held_valid"}, 32'(rsp_valid[d]), 32'd0);
        check({tag, " held_ready"}, 32'(req_ready[d]), 32'd1);
        rst[d] = 1'b0;
    endtask

    task automatic b2b(input int d);
        logic [31:0] exp_q [$];
        logic [31:0] e;
        logic        ee;
        int          n_acc;
        int          n_rsp;
        int          cyc;
        int          last_acc;
        string       tag;
        tag      = $sformatf("b2b i%0d", d);
        n_acc    = 0;
        n_rsp    = 0;
        cyc      = 0;
        last_acc = -1;
        @(negedge clk);
        rsp_ready[d] = 1'b1;
        req_wr[d]    = 1'b0;
        req_addr[d]  = $urandom % (NMEM * 4);
        req_valid[d] = 1'b1;
        while ((n_acc < 10 || n_rsp < 10) && cyc < 200) begin
            if (rsp_valid[d]) begin
                check({tag, " ready_in_resp"}, 32'(req_ready[d]), 32'd0);
                if (exp_q.size() == 0) begin
                    check({tag, " extra_rsp"}, 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check({tag, " data"}, rsp_rdata[d], e);
                end
                n_rsp++;
            end
            if (req_valid[d] && req_ready[d]) begin
                model(d, 1'b0, req_addr[d], 32'd0, 4'd0, e, ee);
                exp_q.push_back(e);
                if (last_acc >= 0) check({tag, " gap"}, 32'(cyc - last_acc), 32'(wait_of(d) + 2));
                last_acc = cyc;
                n_acc++;
                @(negedge clk);
                cyc++;
                if (n_acc < 10) req_addr[d] = $urandom % (NMEM * 4);
                else            req_valid[d] = 1'b0;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        rsp_ready[d] = 1'b0;
        req_valid[d] = 1'b0;
        check({tag, " accepts"}, 32'(n_acc), 32'd10);
        check({tag, " responses"}, 32'(n_rsp), 32'd10);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;

        n_checks = 0;
        n_errors = 0;

        vecs[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 0, 32'hDEADBEEF, 1'b0};
        vecs[1]  = '{1'b0, 32'h10,  32'h0,        4'h0, 2, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h10,  32'h11223344, 4'h5, 0, 32'hDE22BE44, 1'b0};
        vecs[3]  = '{1'b0, 32'h13,  32'h0,        4'h0, 4, 32'hDE22BE44, 1'b0};
        vecs[4]  = '{1'b1, 32'h14,  32'hFFFFFFFF, 4'h0, 1, 32'hC0DE0005, 1'b0};
        vecs[5]  = '{1'b0, 32'h14,  32'h0,        4'h0, 0, 32'hC0DE0005, 1'b0};
        vecs[6]  = '{1'b1, 32'h20,  32'h12345678, 4'hF, 0, 32'h12345678, 1'b0};
`ifdef DMEM_RESP_ERR_EN
        vecs[7]  = '{1'b1, 32'h200, 32'hCAFEF00D, 4'hF, 1, 32'h0,        1'b1};
        vecs[8]  = '{1'b0, 32'h0,   32'h0,        4'h0, 0, 32'hC0DE0000, 1'b0};
        vecs[9]  = '{1'b0, 32'h204, 32'h0,        4'h0, 0, 32'h0,        1'b1};
`else
        vecs[7]  = '{1'b1, 32'h200, 32'hCAFEF00D, 4'hF, 1, 32'hCAFEF00D, 1'b0};
        vecs[8]  = '{1'b0, 32'h0,   32'h0,        4'h0, 0, 32'hCAFEF00D, 1'b0};
        vecs[9]  = '{1'b0, 32'h204, 32'h0,        4'h0, 0, 32'hC0DE0001, 1'b0};
`endif
        vecs[10] = '{1'b0, 32'h1FC, 32'h0,        4'h0, 0, 32'hC0DE007F, 1'b0};

        rst       = 2'b11;
        req_valid = 2'b00;
        req_wr    = 2'b00;
        rsp_ready = 2'b00;
        for (int d = 0; d < 2; d++) begin
            req_addr[d]  = '0;
            req_wdata[d] = '0;
            req_be[d]    = '0;
        end

        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset i%0d req_ready", d), 32'(req_ready[d]), 32'd1);
            check($sformatf("reset i%0d rsp_valid", d), 32'(rsp_valid[d]), 32'd0);
            check($sformatf("reset i%0d rsp_rdata", d), rsp_rdata[d], 32'd0);
            check($sformatf("reset i%0d rsp_err", d), 32'(rsp_err[d]), 32'd0);
        end
        repeat (3) @(negedge clk);
        rst = 2'b00;

        // Known contents everywhere so every later read has a defined expectation.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < NMEM; i++) begin
                wdata = {16'hC0DE, 16'(i)};
                do_txn(d, 1'b1, 32'(i * 4), wdata, 4'hF, 0, rd, er);
                model(d, 1'b1, 32'(i * 4), wdata, 4'hF, exp_rd, exp_err);
                check($sformatf("init i%0d w%0d", d, i), rd, wdata);
            end
        end

        for (int d = 0; d < 2; d++) begin
            for (int v = 0; v < 11; v++) begin
                do_txn(d, vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].be, vecs[v].hold, rd, er);
                model(d, vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].be, exp_rd, exp_err);
                check($sformatf("vec%0d i%0d rdata", v, d), rd, vecs[v].exp_rd);
                check($sformatf("vec%0d i%0d err", v, d), 32'(er), 32'(vecs[v].exp_err));
            end
        end

        // Writes caught in WAIT must be dropped; word 0x20 keeps 0x12345678.
        rst_mid(0, 1'b1, 32'h20, 32'h55AA55AA, 1, 1'b0);
        do_txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er);
        check("rst_wait1 readback", rd, 32'h12345678);
        rst_mid(0, 1'b1, 32'h20, 32'h55AA55AA, 2, 1'b0);
        do_txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er);
        check("rst_wait0 readback", rd, 32'h12345678);
        rst_mid(0, 1'b0, 32'h20, 32'h0, 3, 1'b1);
        do_txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er);
        check("rst_resp readback", rd, 32'h12345678);

        b2b(0);
        b2b(1);

        for (int d = 0; d < 2; d++) begin
            for (int t = 0; t < 60; t++) begin
                wr    = 1'($urandom);
                addr  = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom % (NMEM * 4));
                wdata = $urandom;
                be    = 4'($urandom);
                do_txn(d, wr, addr, wdata, be, $urandom_range(0, 2), rd, er);
                model(d, wr, addr, wdata, be, exp_rd, exp_err);
                check($sformatf("rand%0d i%0d rdata", t, d), rd, exp_rd);
                check($sformatf("rand%0d i%0d err", t, d), 32'(er), 32'(exp_err));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
